// File: rtl/uart_rx_axis.sv
// uart_rx_axis: UART receiver that turns an asynchronous 8N1-style serial line into an
// AXI-Stream byte source with a single output register. The line cannot be stalled.
// When a word completes while the output register is still occupied, the new word is
// dropped and overrun pulses. A low stop bit pulses frame_err.
//
// Ports:
//   clk            system clock
//   arstn          asynchronous active-low reset
//   rxd            serial input, idle high, asynchronous to clk
//   m_axis_tdata   received word (DATA_WIDTH bits, first received bit in bit 0)
//   m_axis_tvalid  word valid
//   m_axis_tready  downstream ready
//   frame_err      one-cycle pulse: stop bit sampled low, word discarded
//   overrun        one-cycle pulse: completed word dropped, output register occupied
module uart_rx_axis #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int unsigned CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W        = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // START lasts half a bit so that every later sample lands mid-bit.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_check
        $error("uart_rx_axis: CLKS_PER_BIT must be at least 4");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_dw_check
        $error("uart_rx_axis: DATA_WIDTH must be in 5..9");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    // Synchroniser and FSM state
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  w_rx_s;
    state_e                r_state;
    state_e                w_state_nxt;

    // Datapath registers
    logic [CNT_W-1:0]      r_clk_cnt;
    logic [BIT_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_frame_err;
    logic                  r_overrun;

    // Decoded FSM outputs
    logic                  w_cnt_run;
    logic                  w_data_sample;
    logic                  w_stop_sample;
    logic                  w_deliver;
    logic                  w_load;
    logic                  w_ovr;
    logic                  w_ferr;

    // 2-FF synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // FSM: state register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (!w_rx_s) begin
                    w_state_nxt = StStart;
                end
            end
            StStart: begin
                if (r_clk_cnt == CNT_HALF) begin
                    w_state_nxt = w_rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (r_clk_cnt == CNT_LAST && r_bit_idx == BIT_LAST) begin
                    w_state_nxt = StStop;
                end
            end
            StStop: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_state_nxt = w_rx_s ? StIdle : StBreak;
                end
            end
            StBreak: begin
                // Stay here while the line is low so a break is never taken as a start bit.
                if (w_rx_s) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // FSM: output decode
    always_comb begin
        w_cnt_run     = 1'b0;
        w_data_sample = 1'b0;
        w_stop_sample = 1'b0;
        unique case (r_state)
            StStart: begin
                w_cnt_run = 1'b1;
            end
            StData: begin
                w_cnt_run     = 1'b1;
                w_data_sample = (r_clk_cnt == CNT_LAST);
            end
            StStop: begin
                w_cnt_run     = 1'b1;
                w_stop_sample = (r_clk_cnt == CNT_LAST);
            end
            default: begin
                w_cnt_run = 1'b0;
            end
        endcase

        w_deliver = w_stop_sample && w_rx_s;
        w_ferr    = w_stop_sample && !w_rx_s;
        // A word in the output register that is being accepted this cycle frees the slot.
        w_load    = w_deliver && (!r_tvalid || m_axis_tready);
        w_ovr     = w_deliver && r_tvalid && !m_axis_tready;
    end

    // Clock counter: reloads on every state change and after each data sample.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_clk_cnt <= '0;
        end else if (w_state_nxt != r_state || w_data_sample || !w_cnt_run) begin
            r_clk_cnt <= '0;
        end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
        end
    end

    // Bit index and shift register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else if (r_state == StStart) begin
            r_bit_idx <= '0;
        end else if (w_data_sample) begin
            r_shift[r_bit_idx] <= w_rx_s;
            r_bit_idx          <= r_bit_idx + BIT_W'(1);
        end
    end

    // Output register and status pulses
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= w_ovr;
            if (w_load) begin
                r_tdata  <= r_shift;
                r_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign frame_err     = r_frame_err;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Testbench for uart_rx_axis at 16 clocks per bit, 8 data bits.
module tb_uart_rx_axis;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic       rxd = 1'b1;
    logic       tready = 1'b0;
    logic [7:0] tdata;
    logic       tvalid;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state; only the monitor writes these, tasks compare deltas.
    logic [7:0] got_q[$];
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         both_cnt = 0;
    int         stab_err = 0;
    time        t_rise = 0;
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;

    always #5 clk = ~clk;

    uart_rx_axis #(
        .CLK_FREQ  (16000000),
        .BAUD      (1000000),
        .DATA_WIDTH(8)
    ) dut (
        .clk          (clk),
        .arstn        (arstn),
        .rxd          (rxd),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    // tready only changes just after posedge, so its negedge value is the one used at the
    // following posedge handshake.
    always @(negedge clk) begin
        if (!arstn) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (prev_v && !prev_r && (!tvalid || tdata !== prev_d)) stab_err++;
            if (tvalid && !prev_v) t_rise = $time;
            if (tvalid && tready) got_q.push_back(tdata);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (frame_err && overrun) both_cnt++;
            prev_v = tvalid;
            prev_r = tready;
            prev_d = tdata;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is at posedge+1; every bit lasts exactly CPB clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(CPB);
        end
        rxd = stop;
        idle(CPB);
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        #1;
        n_checks++;
        if (tvalid !== 1'b0) begin
            n_errors++; $display("FAIL reset_tvalid: got %b want 0", tvalid);
        end
        n_checks++;
        if (tdata !== 8'h00) begin
            n_errors++; $display("FAIL reset_tdata: got %h want 00", tdata);
        end
        n_checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            n_errors++; $display("FAIL reset_flags: got %b%b want 00", frame_err, overrun);
        end
        idle(3);
        arstn = 1'b1;
        idle(10);
        n_checks++;
        if (tvalid !== 1'b0) begin
            n_errors++; $display("FAIL post_reset_tvalid: got %b want 0", tvalid);
        end
    endtask

    task automatic test_single();
        int  b0, f0, o0, lat;
        time t0;
        tready = 1'b1;
        idle(4);
        b0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        t0 = $time;
        send_frame(8'hA5, 1'b1);
        idle(20);
        n_checks++;
        if (got_q.size() - b0 !== 1) begin
            n_errors++; $display("FAIL single_count: got %0d want 1", got_q.size() - b0);
        end else begin
            n_checks++;
            if (got_q[b0] !== 8'hA5) begin
                n_errors++; $display("FAIL single_data: got %h want a5", got_q[b0]);
            end
        end
        lat = int'((t_rise - t0) / 10);
        n_checks++;
        if (t_rise < t0 || lat < 152 || lat > 156) begin
            n_errors++; $display("FAIL single_latency: got %0d want 152..156", lat);
        end
        n_checks++;
        if (ferr_cnt != f0 || ovr_cnt != o0) begin
            n_errors++; $display("FAIL single_flags: got ferr %0d ovr %0d want 0 0",
                                 ferr_cnt - f0, ovr_cnt - o0);
        end
    endtask

    task automatic test_back_to_back();
        int b0, f0;
        tready = 1'b1;
        b0 = got_q.size(); f0 = ferr_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        n_checks++;
        if (got_q.size() - b0 !== 2) begin
            n_errors++; $display("FAIL b2b_count: got %0d want 2", got_q.size() - b0);
        end else begin
            n_checks++;
            if (got_q[b0] !== 8'h00 || got_q[b0+1] !== 8'hFF) begin
                n_errors++; $display("FAIL b2b_data: got %h %h want 00 ff",
                                     got_q[b0], got_q[b0+1]);
            end
        end
        n_checks++;
        if (ferr_cnt != f0) begin
            n_errors++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt - f0);
        end
    endtask

    task automatic test_overrun();
        int b0, o0, f0;
        tready = 1'b0;
        b0 = got_q.size(); o0 = ovr_cnt; f0 = ferr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(8);
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 8'h11) begin
            n_errors++; $display("FAIL ovr_hold: got v=%b d=%h want v=1 d=11", tvalid, tdata);
        end
        n_checks++;
        if (ovr_cnt - o0 !== 1 || ferr_cnt != f0) begin
            n_errors++; $display("FAIL ovr_pulse: got ovr %0d ferr %0d want 1 0",
                                 ovr_cnt - o0, ferr_cnt - f0);
        end
        tready = 1'b1;
        idle(40);
        n_checks++;
        if (got_q.size() - b0 !== 1) begin
            n_errors++; $display("FAIL ovr_drain_count: got %0d want 1", got_q.size() - b0);
        end else begin
            n_checks++;
            if (got_q[b0] !== 8'h11) begin
                n_errors++; $display("FAIL ovr_drain_data: got %h want 11", got_q[b0]);
            end
        end
    endtask

    task automatic test_load_same_cycle();
        int b0, o0;
        tready = 1'b0;
        b0 = got_q.size(); o0 = ovr_cnt;
        send_frame(8'h33, 1'b1);
        fork
            send_frame(8'h44, 1'b1);
            begin
                // The stop sample of this frame is in the cycle ending at edge 155.
                idle(154);
                tready = 1'b1;
                idle(1);
                tready = 1'b0;
                @(negedge clk);
                n_checks++;
                if (tvalid !== 1'b1 || tdata !== 8'h44) begin
                    n_errors++; $display("FAIL same_cycle_load: got v=%b d=%h want v=1 d=44",
                                         tvalid, tdata);
                end
                n_checks++;
                if (got_q.size() - b0 !== 1 || got_q[b0] !== 8'h33) begin
                    n_errors++; $display("FAIL same_cycle_accept: got %0d beats want 1 (33)",
                                         got_q.size() - b0);
                end
            end
        join
        n_checks++;
        if (ovr_cnt != o0) begin
            n_errors++; $display("FAIL same_cycle_ovr: got %0d want 0", ovr_cnt - o0);
        end
        tready = 1'b1;
        idle(10);
        n_checks++;
        if (got_q.size() - b0 !== 2 || got_q[b0+1] !== 8'h44) begin
            n_errors++; $display("FAIL same_cycle_second: got %0d beats want 2 (33 44)",
                                 got_q.size() - b0);
        end
    endtask

    task automatic test_break();
        int b0, f0, o0;
        tready = 1'b1;
        b0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h3C, 1'b0);
        idle(20 * CPB);
        rxd = 1'b1;
        idle(3 * CPB);
        send_frame(8'h5A, 1'b1);
        idle(20);
        n_checks++;
        if (ferr_cnt - f0 !== 1) begin
            n_errors++; $display("FAIL break_ferr: got %0d want 1", ferr_cnt - f0);
        end
        n_checks++;
        if (got_q.size() - b0 !== 1) begin
            n_errors++; $display("FAIL break_count: got %0d want 1", got_q.size() - b0);
        end else begin
            n_checks++;
            if (got_q[b0] !== 8'h5A) begin
                n_errors++; $display("FAIL break_data: got %h want 5a", got_q[b0]);
            end
        end
        n_checks++;
        if (ovr_cnt != o0 || both_cnt != 0) begin
            n_errors++; $display("FAIL break_ovr: got ovr %0d both %0d want 0 0",
                                 ovr_cnt - o0, both_cnt);
        end
    endtask

    task automatic test_glitch();
        int b0, f0, o0;
        tready = 1'b1;
        b0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt;
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(40);
        n_checks++;
        if (got_q.size() != b0 || ferr_cnt != f0 || ovr_cnt != o0 || tvalid !== 1'b0) begin
            n_errors++; $display("FAIL glitch_quiet: got beats %0d ferr %0d ovr %0d want 0 0 0",
                                 got_q.size() - b0, ferr_cnt - f0, ovr_cnt - o0);
        end
        send_frame(8'h96, 1'b1);
        idle(20);
        n_checks++;
        if (got_q.size() - b0 !== 1 || got_q[b0] !== 8'h96) begin
            n_errors++; $display("FAIL glitch_recover: got %0d beats want 1 (96)",
                                 got_q.size() - b0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int b0;
        tready = 1'b0;
        send_frame(8'h77, 1'b1);
        idle(4);
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 8'h77) begin
            n_errors++; $display("FAIL rst_setup: got v=%b d=%h want v=1 d=77", tvalid, tdata);
        end
        b0 = got_q.size();
        rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            idle(CPB);
        end
        rxd = 1'b0;
        idle(CPB / 2);
        arstn = 1'b0;
        #1;
        n_checks++;
        if (tvalid !== 1'b0 || tdata !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            n_errors++; $display("FAIL rst_mid_outputs: got v=%b d=%h fe=%b ov=%b want 0 00 0 0",
                                 tvalid, tdata, frame_err, overrun);
        end
        rxd = 1'b1;
        idle(5);
        arstn = 1'b1;
        idle(40);
        tready = 1'b1;
        idle(4);
        send_frame(8'h81, 1'b1);
        idle(20);
        n_checks++;
        if (got_q.size() - b0 !== 1) begin
            n_errors++; $display("FAIL rst_resume_count: got %0d want 1", got_q.size() - b0);
        end else begin
            n_checks++;
            if (got_q[b0] !== 8'h81) begin
                n_errors++; $display("FAIL rst_resume_data: got %h want 81", got_q[b0]);
            end
        end
    endtask

    // Random frames, gaps, stop-bit faults and a random per-cycle tready. Loads are at
    // least one frame apart, so with random tready the output register always drains.
    task automatic test_random();
        logic [7:0] exp_q[$];
        int         exp_ferr;
        int         b0, f0, o0, s0;
        bit         done;
        b0 = got_q.size(); f0 = ferr_cnt; o0 = ovr_cnt; s0 = stab_err;
        exp_ferr = 0;
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 12; n++) begin
                    logic [7:0] b;
                    logic       good;
                    b    = 8'($urandom);
                    good = ($urandom_range(0, 3) != 0);
                    send_frame(b, good);
                    if (good) begin
                        exp_q.push_back(b);
                        idle($urandom_range(0, 40));
                    end else begin
                        exp_ferr++;
                        idle($urandom_range(1, 3) * CPB);
                        rxd = 1'b1;
                        idle(CPB + $urandom_range(0, 20));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    tready = 1'($urandom_range(0, 1));
                end
                tready = 1'b1;
            end
        join
        idle(30);
        n_checks++;
        if (got_q.size() - b0 !== exp_q.size()) begin
            n_errors++; $display("FAIL rand_count: got %0d want %0d",
                                 got_q.size() - b0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[b0+i] !== exp_q[i]) begin
                    n_errors++; $display("FAIL rand_data[%0d]: got %h want %h",
                                         i, got_q[b0+i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (ferr_cnt - f0 !== exp_ferr) begin
            n_errors++; $display("FAIL rand_ferr: got %0d want %0d", ferr_cnt - f0, exp_ferr);
        end
        n_checks++;
        if (ovr_cnt != o0 || both_cnt != 0) begin
            n_errors++; $display("FAIL rand_ovr: got ovr %0d both %0d want 0 0",
                                 ovr_cnt - o0, both_cnt);
        end
        n_checks++;
        if (stab_err != s0) begin
            n_errors++; $display("FAIL rand_stable: got %0d tdata changes want 0",
                                 stab_err - s0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_load_same_cycle();
        test_break();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        n_checks++;
        if (stab_err != 0) begin
            n_errors++; $display("FAIL tdata_stable: got %0d changes want 0", stab_err);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
